report_status_arbiter: RTL and testbench
========================================

Name: report_status_arbiter

Overview:
- Shares the single MMIO status-report channel (64-bit report word plus ack) among NUM_REQ completion/status sources, e.g. done logic, error reporter and statistics dumper.
- Each source gets a one-entry capture slot. A round-robin FSM presents one captured word at a time to the MMIO block and holds it until acknowledged.
- Sits between the per-engine done/status controllers and the MMIO register file in the AFU.

Parameters:
- NUM_REQ, 4: number of report sources, 2..8.
- DATA_W, 64: report word width.
- SRC_W, $clog2(NUM_REQ): source index width.

Ports:
- clock  in  1  AFU clock
- rstn  in  1  asynchronous active-low reset
- soft_rstn  in  1  synchronous active-low soft reset
- enabled_in  in  1  block enable, registered internally
- req_valid  in  NUM_REQ  per-source report valid
- req_data  in  NUM_REQ x DATA_W  per-source report word
- req_ready  out  NUM_REQ  per-source slot free
- report_status  out  DATA_W  word presented to MMIO
- report_valid  out  1  report_status valid
- report_source  out  SRC_W  index of the presented source
- report_ack  in  1  MMIO consumed report
- report_count  out  32  completed reports, saturating
- busy  out  1  any slot full or report outstanding

Behaviour:
- Reset (rstn low, asynchronous) clears:
  - enabled, all slots, report_status, report_valid, report_source, report_count.
  - last_grant set to NUM_REQ-1, so source 0 has first priority.
  - State set to ARB_RESET.
- soft_rstn low, sampled at clock edge: same clears, but state goes to ARB_IDLE. An outstanding report is dropped without waiting for ack.
- enabled is enabled_in delayed one cycle.
- While enabled=0:
  - FSM, slots and counter hold.
  - req_ready forced to 0.
  - Outputs keep their values.
- req_ready[i] = enabled & ~slot_full[i], combinational.
- Capture: on a clock edge with req_valid[i] & req_ready[i], slot_data[i] <= req_data[i] and slot_full[i] <= 1.
- FSM states:
  - ARB_RESET: goes to ARB_IDLE. Outputs are zero.
  - ARB_IDLE:
    - If any slot is full, pick winner w = first full slot searching from (last_grant+1) mod NUM_REQ upward with wrap.
    - On that edge: report_status <= slot_data[w], report_source <= w, report_valid <= 1, last_grant <= w. Go to ARB_MMIO_REQ.
    - Otherwise stay in ARB_IDLE, with report_status = 0 and report_valid = 0.
  - ARB_MMIO_REQ:
    - Outputs held stable.
    - If report_ack: slot_full[report_source] <= 0, report_valid <= 0, report_status <= 0, report_count increments (saturates at 0xFFFFFFFF). Go to ARB_IDLE.
    - Otherwise stay.
- Latency:
  - Word captured at edge t: report_valid is high after edge t+1 if the FSM is idle and this source wins.
  - Ack sampled at edge a: next report presented after edge a+1 at the earliest (one idle cycle between reports).
  - Freed slot: req_ready rises after edge a, so the slot can refill at edge a+1.
- report_ack outside ARB_MMIO_REQ is ignored (no count, no slot change).
- A capture into the presented slot while it is presented is impossible, because that slot is full.
- Captures into other slots proceed during ARB_MMIO_REQ.
- busy = |slot_full | report_valid.
- Round-robin guarantee: with all sources continuously refilling, each source is served once every NUM_REQ reports.

Test Plan:
- Reset then single request: req_valid[2]=1, req_data[2]=0xDEAD_BEEF_0000_0002 for one cycle. Expect report_valid high 1 cycle after capture, report_source=2 and report_status equal to that word. Hold 5 cycles without ack and check stability. Ack: report_valid=0 next cycle, report_count=1, req_ready[2]=1.
- Fairness: all 4 sources valid at the same edge with data 0x10..0x13, ack each report 2 cycles after report_valid. Expect grant order 0,1,2,3. Refill all and expect order 0,1,2,3 again (last_grant=3 wraps to 0). report_count=8.
- Priority rotation: after serving source 1, sources 0 and 3 both full. Expect 3 before 0.
- Spurious ack and enable: pulse report_ack in ARB_IDLE and expect no count change. Drop enabled_in mid ARB_MMIO_REQ and pulse ack. Expect no state change, req_ready=0, outputs held. Re-enable and ack: completes normally.
- Soft reset mid-report: with 3 slots full and one presented, pull soft_rstn low for 1 cycle. Expect report_valid=0, all req_ready=1 next enabled cycle, report_count=0, next grant starting at source 0.
- Saturation: force report_count to 0xFFFF_FFFE, complete 3 reports. Expect 0xFFFF_FFFF held.

Source files
------------

// File: rtl/report_status_arbiter_if.sv
// Report channel between status sources, the arbiter and the MMIO block.
// Carries per-source capture handshakes plus the single presented report.
interface report_status_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int SRC_W   = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [DATA_W-1:0]              report_status;
  logic                           report_valid;
  logic [SRC_W-1:0]               report_source;
  logic                           report_ack;

  modport master (
    output req_valid,
    output req_data,
    output report_ack,
    input  req_ready,
    input  report_status,
    input  report_valid,
    input  report_source
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  report_ack,
    output req_ready,
    output report_status,
    output report_valid,
    output report_source
  );

endinterface

// File: rtl/report_status_arbiter.sv
// Round-robin arbiter sharing one MMIO status-report channel
// between NUM_REQ sources, each with a one-entry capture slot.
module report_status_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     soft_rstn,
  input  logic                     enabled_in,
  report_status_arbiter_if.slave   bus,
  output logic [31:0]              report_count,
  output logic                     busy
);

  typedef enum logic [1:0] {
    ARB_RESET,
    ARB_IDLE,
    ARB_MMIO_REQ
  } state_t;

  state_t                         state;
  logic                           enabled;
  logic [NUM_REQ-1:0]             slot_full;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot_data;
  logic [SRC_W-1:0]               last_grant;
  logic [SRC_W-1:0]               src_q;
  logic [DATA_W-1:0]              status_q;
  logic                           valid_q;
  logic [31:0]                    count_q;

  logic [SRC_W-1:0]               win;
  logic [SRC_W-1:0]               idx;
  logic                           found;

  // First full slot after the last grant, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = SRC_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && slot_full[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state      <= ARB_RESET;
      enabled    <= 1'b0;
      slot_full  <= '0;
      slot_data  <= '0;
      last_grant <= SRC_W'(NUM_REQ - 1);
      src_q      <= '0;
      status_q   <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else if (!soft_rstn) begin
      state      <= ARB_IDLE;
      enabled    <= 1'b0;
      slot_full  <= '0;
      slot_data  <= '0;
      last_grant <= SRC_W'(NUM_REQ - 1);
      src_q      <= '0;
      status_q   <= '0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      enabled <= enabled_in;
      if (enabled) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (bus.req_valid[i] && !slot_full[i]) begin
            slot_full[i] <= 1'b1;
            slot_data[i] <= bus.req_data[i];
          end
        end
        unique case (state)
          ARB_RESET: begin
            status_q <= '0;
            valid_q  <= 1'b0;
            state    <= ARB_IDLE;
          end
          ARB_IDLE: begin
            if (found) begin
              status_q   <= slot_data[win];
              src_q      <= win;
              valid_q    <= 1'b1;
              last_grant <= win;
              state      <= ARB_MMIO_REQ;
            end else begin
              status_q <= '0;
              valid_q  <= 1'b0;
            end
          end
          ARB_MMIO_REQ: begin
            if (bus.report_ack) begin
              slot_full[src_q] <= 1'b0;
              valid_q          <= 1'b0;
              status_q         <= '0;
              if (count_q != 32'hFFFF_FFFF)
                count_q <= count_q + 32'd1;
              state <= ARB_IDLE;
            end
          end
          default: state <= ARB_IDLE;
        endcase
      end
    end
  end

  assign bus.req_ready     = {NUM_REQ{enabled}} & ~slot_full;
  assign bus.report_status = status_q;
  assign bus.report_valid  = valid_q;
  assign bus.report_source = src_q;
  assign report_count      = count_q;
  assign busy              = (|slot_full) | valid_q;

endmodule

// File: tb/tb_report_status_arbiter.sv
// Directed bench for report_status_arbiter: vector table for
// round-robin/enable behaviour plus hand sequences for resets.
module tb_report_status_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;

  logic        clock;
  logic        rstn;
  logic        soft_rstn;
  logic        enabled_in;
  logic [31:0] report_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  report_status_arbiter_if #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W)
  ) bus ();

  report_status_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W (DATA_W)
  ) dut (
    .clock       (clock),
    .rstn        (rstn),
    .soft_rstn   (soft_rstn),
    .enabled_in  (enabled_in),
    .bus         (bus),
    .report_count(report_count),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  v;
    logic        ack;
    logic        en;
    logic        ev;
    logic [1:0]  es;
    logic [63:0] estat;
    logic [3:0]  erdy;
    logic [31:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic [3:0]  v,
    input logic        ack,
    input logic        en,
    input logic        ev,
    input logic [1:0]  es,
    input logic [3:0]  erdy,
    input logic [31:0] ecnt
  );
    vec_t r;
    r.v     = v;
    r.ack   = ack;
    r.en    = en;
    r.ev    = ev;
    r.es    = es;
    r.estat = ev ? (64'h10 + 64'(es)) : 64'h0;
    r.erdy  = erdy;
    r.ecnt  = ecnt;
    tbl.push_back(r);
  endtask

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hard_reset(input bit check);
    rstn          = 1'b0;
    soft_rstn     = 1'b1;
    enabled_in    = 1'b1;
    bus.req_valid = '0;
    bus.report_ack = 1'b0;
    repeat (2) tick();
    if (check) begin
      chk("rst valid", 64'(bus.report_valid), 64'h0);
      chk("rst status", bus.report_status, 64'h0);
      chk("rst ready", 64'(bus.req_ready), 64'h0);
      chk("rst count", 64'(report_count), 64'h0);
      chk("rst busy", 64'(busy), 64'h0);
    end
    rstn = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    logic [3:0] rb;
    logic [3:0] ra;
    for (int p = 0; p < 2; p++) begin
      add(4'hF, 0, 1, 0, p[0] ? 2'd3 : 2'd0, 4'h0, 32'(p * 4));
      for (int s = 0; s < 4; s++) begin
        rb = 4'((1 << s) - 1);
        ra = 4'((1 << (s + 1)) - 1);
        add(4'h0, 0, 1, 1, 2'(s), rb, 32'(p * 4 + s));
        add(4'h0, 0, 1, 1, 2'(s), rb, 32'(p * 4 + s));
        add(4'h0, 1, 1, 0, 2'(s), ra, 32'(p * 4 + s + 1));
      end
    end
    add(4'b0010, 0, 1, 0, 2'd3, 4'b1101, 8);
    add(4'b1001, 0, 1, 1, 2'd1, 4'b0100, 8);
    add(4'b0000, 1, 1, 0, 2'd1, 4'b0110, 9);
    add(4'b0000, 0, 1, 1, 2'd3, 4'b0110, 9);
    add(4'b0000, 1, 1, 0, 2'd3, 4'b1110, 10);
    add(4'b0000, 0, 1, 1, 2'd0, 4'b1110, 10);
    add(4'b0000, 1, 1, 0, 2'd0, 4'b1111, 11);
    add(4'b0000, 1, 1, 0, 2'd0, 4'b1111, 11);
    add(4'b0100, 0, 1, 0, 2'd0, 4'b1011, 11);
    add(4'b0000, 0, 1, 1, 2'd2, 4'b1011, 11);
    add(4'b0000, 0, 0, 1, 2'd2, 4'b0000, 11);
    add(4'b0000, 1, 0, 1, 2'd2, 4'b0000, 11);
    add(4'b0000, 1, 1, 1, 2'd2, 4'b1011, 11);
    add(4'b0000, 1, 1, 0, 2'd2, 4'b1111, 12);
    add(4'b0000, 0, 1, 0, 2'd2, 4'b1111, 12);

    bus.req_data = '0;
    hard_reset(1'b1);

    // single request from source 2
    bus.req_data[2]  = 64'hDEAD_BEEF_0000_0002;
    bus.req_valid    = 4'b0100;
    tick();
    bus.req_valid = '0;
    chk("t1 cap valid", 64'(bus.report_valid), 64'h0);
    chk("t1 cap ready", 64'(bus.req_ready), 64'hB);
    tick();
    chk("t1 valid", 64'(bus.report_valid), 64'h1);
    chk("t1 source", 64'(bus.report_source), 64'h2);
    chk("t1 status", bus.report_status, 64'hDEAD_BEEF_0000_0002);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t1 hold%0d valid", i),
          64'(bus.report_valid), 64'h1);
      chk($sformatf("t1 hold%0d status", i),
          bus.report_status, 64'hDEAD_BEEF_0000_0002);
    end
    chk("t1 busy", 64'(busy), 64'h1);
    bus.report_ack = 1'b1;
    tick();
    bus.report_ack = 1'b0;
    chk("t1 ack valid", 64'(bus.report_valid), 64'h0);
    chk("t1 ack count", 64'(report_count), 64'h1);
    chk("t1 ack ready", 64'(bus.req_ready), 64'hF);
    chk("t1 ack busy", 64'(busy), 64'h0);

    hard_reset(1'b0);
    for (int i = 0; i < NUM_REQ; i++)
      bus.req_data[i] = 64'h10 + 64'(i);
    foreach (tbl[k]) begin
      bus.req_valid  = tbl[k].v;
      bus.report_ack = tbl[k].ack;
      enabled_in     = tbl[k].en;
      tick();
      chk($sformatf("row%0d valid", k),
          64'(bus.report_valid), 64'(tbl[k].ev));
      chk($sformatf("row%0d source", k),
          64'(bus.report_source), 64'(tbl[k].es));
      chk($sformatf("row%0d status", k),
          bus.report_status, tbl[k].estat);
      chk($sformatf("row%0d ready", k),
          64'(bus.req_ready), 64'(tbl[k].erdy));
      chk($sformatf("row%0d count", k),
          64'(report_count), 64'(tbl[k].ecnt));
    end
    bus.req_valid  = '0;
    bus.report_ack = 1'b0;
    enabled_in     = 1'b1;

    // soft reset while source 0 presented, slots 1,2 also full
    bus.req_valid = 4'b0111;
    tick();
    bus.req_valid = '0;
    tick();
    chk("sr pre source", 64'(bus.report_source), 64'h0);
    chk("sr pre valid", 64'(bus.report_valid), 64'h1);
    soft_rstn = 1'b0;
    tick();
    soft_rstn = 1'b1;
    chk("sr valid", 64'(bus.report_valid), 64'h0);
    chk("sr status", bus.report_status, 64'h0);
    chk("sr count", 64'(report_count), 64'h0);
    chk("sr busy", 64'(busy), 64'h0);
    chk("sr ready off", 64'(bus.req_ready), 64'h0);
    tick();
    chk("sr ready on", 64'(bus.req_ready), 64'hF);
    bus.req_valid = 4'b0011;
    tick();
    bus.req_valid = '0;
    tick();
    chk("sr grant source", 64'(bus.report_source), 64'h0);
    chk("sr grant valid", 64'(bus.report_valid), 64'h1);

    // saturation from 0xFFFF_FFFE
    dut.count_q = 32'hFFFF_FFFE;
    bus.report_ack = 1'b1;
    tick();
    bus.report_ack = 1'b0;
    chk("sat 1", 64'(report_count), 64'hFFFF_FFFF);
    tick();
    chk("sat src1", 64'(bus.report_source), 64'h1);
    bus.report_ack = 1'b1;
    tick();
    bus.report_ack = 1'b0;
    chk("sat 2", 64'(report_count), 64'hFFFF_FFFF);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    tick();
    chk("sat src2", 64'(bus.report_source), 64'h2);
    bus.report_ack = 1'b1;
    tick();
    bus.report_ack = 1'b0;
    chk("sat 3", 64'(report_count), 64'hFFFF_FFFF);
    chk("sat valid", 64'(bus.report_valid), 64'h0);
    tick();
    chk("sat hold", 64'(report_count), 64'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
